// File: rtl/sync_fifo_param_if.sv
// sync_fifo_param_if -- request/status bundle for sync_fifo_param.
//   master : drives wr, rd, data_in, thresh_hi, thresh_lo, err_clr;
//            observes data_out, fifo_full/empty/thresh/low,
//            fifo_overflow/underflow, fifo_count.
//   slave  : the FIFO side (directions mirrored).
// CNT_W = log2(DEPTH)+1 so a count of exactly DEPTH is representable.
interface sync_fifo_param_if #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic              wr;
   logic              rd;
   logic [DATA_W-1:0] data_in;
   logic [CNT_W-1:0]  thresh_hi;
   logic [CNT_W-1:0]  thresh_lo;
   logic              err_clr;
   logic [DATA_W-1:0] data_out;
   logic              fifo_full;
   logic              fifo_empty;
   logic              fifo_thresh;
   logic              fifo_low;
   logic              fifo_overflow;
   logic              fifo_underflow;
   logic [CNT_W-1:0]  fifo_count;

   modport master (
      output wr, rd, data_in, thresh_hi, thresh_lo, err_clr,
      input  data_out, fifo_full, fifo_empty, fifo_thresh, fifo_low,
             fifo_overflow, fifo_underflow, fifo_count
   );

   modport slave (
      input  wr, rd, data_in, thresh_hi, thresh_lo, err_clr,
      output data_out, fifo_full, fifo_empty, fifo_thresh, fifo_low,
             fifo_overflow, fifo_underflow, fifo_count
   );
endinterface

// File: rtl/sync_fifo_param.sv
// sync_fifo_param -- single-clock FIFO, DEPTH x DATA_W, with programmable
// almost-full / almost-empty levels and sticky overflow/underflow flags.
//   clk   : sole clock, rising edge
//   reset : synchronous, active-low
//   bus   : sync_fifo_param_if.slave (write/read requests, data, thresholds,
//           err_clr in; data_out, status flags and fifo_count out)
// FWFT=0: data_out registered, updated one edge after an accepted read.
// FWFT=1: data_out continuously shows the word at the read pointer.
module sync_fifo_param #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int FWFT   = 0
) (
   input logic              clk,
   input logic              reset,
   sync_fifo_param_if.slave bus
);
   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = AW + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   // Storage is deliberately not reset; only pointers and count are.
   logic [DATA_W-1:0] mem_q [DEPTH];

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             udf_q, udf_d;
   logic             full, empty, wr_acc, rd_acc;

   always_comb begin
      full   = (count_q == DEPTH_C);
      empty  = (count_q == '0);
      rd_acc = bus.rd && !empty;
      // A write into a full FIFO still lands when a read frees a slot
      // in the same cycle.
      wr_acc = bus.wr && (!full || rd_acc);

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
      if (wr_acc && !rd_acc) count_d = count_q + CNT_W'(1);
      else if (rd_acc && !wr_acc) count_d = count_q - CNT_W'(1);

      // New error event beats a simultaneous clear.
      ovf_d = (bus.wr && !wr_acc) || (ovf_q && !bus.err_clr);
      udf_d = (bus.rd && !rd_acc) || (udf_q && !bus.err_clr);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset && wr_acc) mem_q[wr_ptr_q] <= bus.data_in;
   end

   generate
      if (FWFT != 0) begin : g_fwft
         assign bus.data_out = mem_q[rd_ptr_q];
      end else begin : g_std
         logic [DATA_W-1:0] dout_q, dout_d;

         always_comb begin
            dout_d = dout_q;
            if (rd_acc) dout_d = mem_q[rd_ptr_q];
         end

         always_ff @(posedge clk) begin
            if (!reset) dout_q <= '0;
            else        dout_q <= dout_d;
         end

         assign bus.data_out = dout_q;
      end
   endgenerate

   // thresh_hi=0 and thresh_hi>DEPTH fall out of the plain compare because
   // count_q never exceeds DEPTH.
   assign bus.fifo_full      = full;
   assign bus.fifo_empty     = empty;
   assign bus.fifo_thresh    = (count_q >= bus.thresh_hi);
   assign bus.fifo_low       = (count_q <= bus.thresh_lo);
   assign bus.fifo_overflow  = ovf_q;
   assign bus.fifo_underflow = udf_q;
   assign bus.fifo_count     = count_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
module tb_sync_fifo_param;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 16;
   localparam int CNT_W  = 5;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   logic              s_wr = 0, s_rd = 0, s_clr = 0;
   logic [DATA_W-1:0] s_din = '0;
   logic [CNT_W-1:0]  s_thi = 5'd12, s_tlo = 5'd3;

   sync_fifo_param_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus0 ();
   sync_fifo_param_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus1 ();

   assign bus0.wr = s_wr;      assign bus1.wr = s_wr;
   assign bus0.rd = s_rd;      assign bus1.rd = s_rd;
   assign bus0.data_in = s_din; assign bus1.data_in = s_din;
   assign bus0.err_clr = s_clr; assign bus1.err_clr = s_clr;
   assign bus0.thresh_hi = s_thi; assign bus1.thresh_hi = s_thi;
   assign bus0.thresh_lo = s_tlo; assign bus1.thresh_lo = s_tlo;

   sync_fifo_param #(.DATA_W(DATA_W), .DEPTH(DEPTH), .FWFT(0)) dut0 (
      .clk(clk), .reset(reset_n), .bus(bus0.slave));
   sync_fifo_param #(.DATA_W(DATA_W), .DEPTH(DEPTH), .FWFT(1)) dut1 (
      .clk(clk), .reset(reset_n), .bus(bus1.slave));

   int total = 0;
   int bad = 0;

   // Reference model: a queue of stored words plus sticky flags.
   logic [7:0] q[$];
   bit         m_ovf = 0, m_udf = 0;
   logic [7:0] m_dout = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input bit rst_n, input bit w, input bit r, input logic [7:0] d, input bit c);
      reset_n = rst_n; s_wr = w; s_rd = r; s_din = d; s_clr = c;
   endtask

   task automatic check_model();
      int sz = q.size();
      check("count0", 64'(bus0.fifo_count), 64'(sz));
      check("full0", 64'(bus0.fifo_full), 64'(sz == DEPTH));
      check("empty0", 64'(bus0.fifo_empty), 64'(sz == 0));
      check("thresh0", 64'(bus0.fifo_thresh), 64'(sz >= int'(s_thi)));
      check("low0", 64'(bus0.fifo_low), 64'(sz <= int'(s_tlo)));
      check("ovf0", 64'(bus0.fifo_overflow), 64'(m_ovf));
      check("udf0", 64'(bus0.fifo_underflow), 64'(m_udf));
      check("dout0", 64'(bus0.data_out), 64'(m_dout));
      check("count1", 64'(bus1.fifo_count), 64'(sz));
      check("ovf1", 64'(bus1.fifo_overflow), 64'(m_ovf));
      check("udf1", 64'(bus1.fifo_underflow), 64'(m_udf));
      if (sz > 0) check("fwft_head", 64'(bus1.data_out), 64'(q[0]));
   endtask

   // Advance the model by the current inputs, clock once, compare.
   task automatic cycle();
      int  sz = q.size();
      bit  rd_ok, wr_ok;
      if (!reset_n) begin
         q.delete(); m_ovf = 0; m_udf = 0; m_dout = '0;
      end else begin
         rd_ok = s_rd && (sz > 0);
         wr_ok = s_wr && ((sz < DEPTH) || rd_ok);
         m_ovf = (s_wr && !wr_ok) || (m_ovf && !s_clr);
         m_udf = (s_rd && !rd_ok) || (m_udf && !s_clr);
         if (rd_ok) m_dout = q.pop_front();
         if (wr_ok) q.push_back(s_din);
      end
      @(posedge clk); #1;
      check_model();
   endtask

   typedef struct {
      bit         rst_n, wr, rd, clr;
      logic [7:0] din;
      int         cnt;
      bit         ovf, udf;
      logic [7:0] dout;
   } vec_t;
   vec_t tbl[12];

   initial begin
      tbl[0]  = '{0, 1, 0, 0, 8'h77, 0, 0, 0, 8'h00};
      tbl[1]  = '{1, 0, 1, 0, 8'h00, 0, 0, 1, 8'h00};
      tbl[2]  = '{1, 0, 0, 1, 8'h00, 0, 0, 0, 8'h00};
      tbl[3]  = '{1, 1, 0, 0, 8'hA1, 1, 0, 0, 8'h00};
      tbl[4]  = '{1, 1, 0, 0, 8'hA2, 2, 0, 0, 8'h00};
      tbl[5]  = '{1, 0, 1, 0, 8'h00, 1, 0, 0, 8'hA1};
      tbl[6]  = '{1, 1, 1, 0, 8'hB3, 1, 0, 0, 8'hA2};
      tbl[7]  = '{1, 0, 1, 0, 8'h00, 0, 0, 0, 8'hB3};
      tbl[8]  = '{1, 1, 1, 0, 8'hC4, 1, 0, 1, 8'hB3};
      tbl[9]  = '{1, 0, 1, 1, 8'h00, 0, 0, 0, 8'hC4};
      tbl[10] = '{1, 0, 1, 1, 8'h00, 0, 0, 1, 8'hC4};
      tbl[11] = '{1, 0, 0, 1, 8'h00, 0, 0, 0, 8'hC4};

      drive(0, 0, 0, 8'h00, 0);
      cycle();
      cycle();

      // Table vectors: fixed expectations, independent of the model.
      for (int i = 0; i < 12; i++) begin
         drive(tbl[i].rst_n, tbl[i].wr, tbl[i].rd, tbl[i].din, tbl[i].clr);
         cycle();
         check($sformatf("tbl%0d_count", i), 64'(bus0.fifo_count), 64'(tbl[i].cnt));
         check($sformatf("tbl%0d_ovf", i), 64'(bus0.fifo_overflow), 64'(tbl[i].ovf));
         check($sformatf("tbl%0d_udf", i), 64'(bus0.fifo_underflow), 64'(tbl[i].udf));
         check($sformatf("tbl%0d_dout", i), 64'(bus0.data_out), 64'(tbl[i].dout));
      end

      // Fill 0x01..0x10 with thresholds 12/3, then overflow, then drain.
      s_thi = 5'd12; s_tlo = 5'd3;
      drive(0, 0, 0, 8'h00, 0); cycle();
      for (int i = 1; i <= 16; i++) begin
         drive(1, 1, 0, 8'(i), 0); cycle();
         check("fill_low", 64'(bus0.fifo_low), 64'(i <= 3));
         check("fill_thresh", 64'(bus0.fifo_thresh), 64'(i >= 12));
      end
      check("full_flag", 64'(bus0.fifo_full), 64'd1);
      check("full_count", 64'(bus0.fifo_count), 64'd16);
      drive(1, 1, 0, 8'hFF, 0); cycle();
      check("ovf_set", 64'(bus0.fifo_overflow), 64'd1);
      check("ovf_count", 64'(bus0.fifo_count), 64'd16);
      drive(1, 0, 0, 8'h00, 1); cycle();
      for (int i = 1; i <= 16; i++) begin
         drive(1, 0, 1, 8'h00, 0); cycle();
         check("drain_order", 64'(bus0.data_out), 64'(i));
      end
      check("drain_empty", 64'(bus0.fifo_empty), 64'd1);

      // Underflow on empty, data_out holds, then clear.
      drive(1, 0, 1, 8'h00, 0); cycle();
      check("udf_set", 64'(bus0.fifo_underflow), 64'd1);
      check("udf_hold", 64'(bus0.data_out), 64'h10);
      drive(1, 0, 0, 8'h00, 1); cycle();
      check("udf_clr", 64'(bus0.fifo_underflow), 64'd0);

      // Full FIFO with simultaneous wr/rd across pointer wrap.
      for (int i = 0; i < 16; i++) begin
         drive(1, 1, 0, 8'(8'h20 + i), 0); cycle();
      end
      for (int i = 0; i < 20; i++) begin
         drive(1, 1, 1, 8'(8'h40 + i), 0); cycle();
         check("wrap_count", 64'(bus0.fifo_count), 64'd16);
         check("wrap_noovf", 64'(bus0.fifo_overflow), 64'd0);
         check("wrap_order", 64'(bus0.data_out), 64'(i < 16 ? 8'h20 + i : 8'h40 + i - 16));
      end

      // Reset mid-operation discards contents.
      drive(0, 0, 0, 8'h00, 0); cycle();
      for (int i = 0; i < 5; i++) begin
         drive(1, 1, 0, 8'(8'h60 + i), 0); cycle();
      end
      drive(1, 0, 1, 8'h00, 0); cycle();
      drive(0, 1, 0, 8'h99, 0); cycle();
      check("rst_count", 64'(bus0.fifo_count), 64'd0);
      check("rst_empty", 64'(bus0.fifo_empty), 64'd1);
      check("rst_full", 64'(bus0.fifo_full), 64'd0);
      check("rst_dout", 64'(bus0.data_out), 64'd0);
      drive(1, 0, 1, 8'h00, 0); cycle();
      check("rst_then_udf", 64'(bus0.fifo_underflow), 64'd1);

      // FWFT: first word appears without a read.
      drive(0, 0, 0, 8'h00, 0); cycle();
      drive(1, 1, 0, 8'hA5, 0); cycle();
      drive(1, 0, 0, 8'h00, 0);
      check("fwft_a5", 64'(bus1.data_out), 64'hA5);
      cycle();
      check("fwft_a5_hold", 64'(bus1.data_out), 64'hA5);

      // Randomized traffic against the queue model.
      for (int i = 0; i < 3000; i++) begin
         int bias = (i / 500) % 3;
         bit w = ($urandom_range(0, 99) < (bias == 0 ? 70 : bias == 1 ? 30 : 50));
         bit r = ($urandom_range(0, 99) < (bias == 0 ? 30 : bias == 1 ? 70 : 50));
         bit c = ($urandom_range(0, 19) == 0);
         bit rs = ($urandom_range(0, 299) != 0);
         if ((i % 97) == 0) begin
            s_thi = 5'($urandom_range(0, 20));
            s_tlo = 5'($urandom_range(0, 17));
         end
         drive(rs, w, r, 8'($urandom), c);
         cycle();
      end

      drive(1, 0, 0, 8'h00, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
